// File: rtl/sd_init_sequencer_pkg.sv
// Shared encodings for the SD identification sequencer: FSM states, command steps,
// command indices, fixed arguments and error codes.
package sd_init_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_CHECK, ST_PAUSE, ST_DONE, ST_ERROR
  } state_e;

  // Step order matches the command order, so "next command" is step + 1.
  typedef enum logic [2:0] {
    STEP_CMD0, STEP_CMD8, STEP_CMD55, STEP_ACMD41, STEP_CMD2, STEP_CMD3, STEP_CMD7
  } step_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_TIMEOUT      = 3'd1,
    ERR_CMD8_ECHO    = 3'd2,
    ERR_ACMD41_RETRY = 3'd3,
    ERR_ABORT        = 3'd4
  } err_e;

  localparam logic [5:0]  CMD0_IDX   = 6'd0;
  localparam logic [5:0]  CMD8_IDX   = 6'd8;
  localparam logic [5:0]  CMD55_IDX  = 6'd55;
  localparam logic [5:0]  ACMD41_IDX = 6'd41;
  localparam logic [5:0]  CMD2_IDX   = 6'd2;
  localparam logic [5:0]  CMD3_IDX   = 6'd3;
  localparam logic [5:0]  CMD7_IDX   = 6'd7;

  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
  localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;
  localparam logic [11:0] CMD8_ECHO  = 12'h1AA;

  function automatic logic [5:0] step_index(step_e step);
    case (step)
      STEP_CMD0:   return CMD0_IDX;
      STEP_CMD8:   return CMD8_IDX;
      STEP_CMD55:  return CMD55_IDX;
      STEP_ACMD41: return ACMD41_IDX;
      STEP_CMD2:   return CMD2_IDX;
      STEP_CMD3:   return CMD3_IDX;
      default:     return CMD7_IDX;
    endcase
  endfunction

  function automatic logic [31:0] step_arg(step_e step, logic [15:0] rca);
    case (step)
      STEP_CMD8:   return CMD8_ARG;
      STEP_ACMD41: return ACMD41_ARG;
      STEP_CMD7:   return {rca, 16'h0000};
      default:     return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/sd_init_sequencer_counter.sv
// Clearable up-counter used for both the ACMD41 retry count and the retry pause.
module sd_init_sequencer_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  // NOTE: reset is sampled on the clock edge, so it belongs inside the clocked branch,
  // not in the sensitivity list.
  always_ff @(posedge clock) begin
    if (!reset)       count_q <= '0;
    else if (clear_i) count_q <= '0;
    else if (inc_i)   count_q <= count_q + WIDTH'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/sd_init_sequencer.sv
// Runs CMD0, CMD8, (CMD55, ACMD41)*, CMD2, CMD3, CMD7 through cmd_controller and
// reports the card RCA/CCS and the done/error status to the host.
module sd_init_sequencer
  import sd_init_sequencer_pkg::*;
#(
  parameter int MAX_RETRIES = 1000,
  parameter int RETRY_WAIT  = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        cmd_new_command,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_argument,
  output logic        cmd_timeout_en,
  input  logic        cmd_complete,
  input  logic        cmd_timeout,
  input  logic [31:0] cmd_response,
  output logic        busy,
  output logic        init_done,
  output logic        init_error,
  output logic [2:0]  error_code,
  output logic [5:0]  error_cmd,
  output logic [15:0] card_rca,
  output logic        card_ccs
);

  localparam logic [9:0] RETRY_LAST = 10'(MAX_RETRIES - 1);
  localparam logic [7:0] PAUSE_LAST = 8'(RETRY_WAIT - 1);

  state_e      state_q;
  step_e       step_q;
  err_e        code_q;
  logic        new_cmd_q, to_en_q, busy_q, done_q, error_q, ccs_q;
  logic [5:0]  index_q, error_cmd_q;
  logic [31:0] arg_q;
  logic [15:0] rca_q;
  logic [15:0] resp_hi_q;
  logic [11:0] resp_echo_q;

  logic [9:0]  retry_cnt;
  logic [7:0]  pause_cnt;
  logic        busy_state, start_ok, acmd41_busy, retry_inc;
  err_e        fail_code;
  step_e       issue_step;
  logic [15:0] issue_rca;

  // Response bits 15:12 carry nothing this sequencer inspects.
  logic unused_resp;
  assign unused_resp = ^cmd_response[15:12];

  assign busy_state  = state_q inside {ST_ISSUE, ST_WAIT, ST_CHECK, ST_PAUSE};
  assign start_ok    = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign acmd41_busy = (step_q == STEP_ACMD41) && !resp_hi_q[15];
  assign retry_inc   = (state_q == ST_CHECK) && acmd41_busy && (fail_code == ERR_NONE);

  // CHECK issues the following command itself, keeping complete -> new_command at two cycles;
  // CMD7 must pick up the RCA being latched on that same edge.
  assign issue_step = (state_q == ST_CHECK) ? step_e'(step_q + 3'd1) : step_q;
  assign issue_rca  = (state_q == ST_CHECK && step_q == STEP_CMD3) ? resp_hi_q : rca_q;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    fail_code = ERR_NONE;
    if (busy_state && abort)
      fail_code = ERR_ABORT;
    else if (state_q == ST_WAIT && cmd_timeout)
      fail_code = ERR_TIMEOUT;
    else if (state_q == ST_CHECK && step_q == STEP_CMD8 && resp_echo_q != CMD8_ECHO)
      fail_code = ERR_CMD8_ECHO;
    else if (state_q == ST_CHECK && acmd41_busy && retry_cnt == RETRY_LAST)
      fail_code = ERR_ACMD41_RETRY;
  end

  sd_init_sequencer_counter #(.WIDTH(10)) u_retry_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear_i (start_ok),
    .inc_i   (retry_inc),
    .count_o (retry_cnt)
  );

  sd_init_sequencer_counter #(.WIDTH(8)) u_pause_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear_i (state_q != ST_PAUSE),
    .inc_i   (state_q == ST_PAUSE),
    .count_o (pause_cnt)
  );

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      step_q      <= STEP_CMD0;
      code_q      <= ERR_NONE;
      new_cmd_q   <= 1'b0;
      to_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      ccs_q       <= 1'b0;
      index_q     <= '0;
      error_cmd_q <= '0;
      arg_q       <= '0;
      rca_q       <= '0;
      resp_hi_q   <= '0;
      resp_echo_q <= '0;
    end else begin
      // NOTE: the command strobe defaults low each cycle, making it a single-cycle pulse.
      new_cmd_q <= 1'b0;
      if (fail_code != ERR_NONE) begin
        state_q     <= ST_ERROR;
        busy_q      <= 1'b0;
        error_q     <= 1'b1;
        code_q      <= fail_code;
        error_cmd_q <= index_q;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_ERROR: if (start) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            code_q      <= ERR_NONE;
            error_cmd_q <= '0;
            rca_q       <= '0;
            ccs_q       <= 1'b0;
            busy_q      <= 1'b1;
            step_q      <= STEP_CMD0;
            state_q     <= ST_ISSUE;
          end
          ST_WAIT: if (cmd_complete) begin
            resp_hi_q   <= cmd_response[31:16];
            resp_echo_q <= cmd_response[11:0];
            state_q     <= ST_CHECK;
          end
          ST_PAUSE: if (pause_cnt == PAUSE_LAST) begin
            step_q  <= STEP_CMD55;
            state_q <= ST_ISSUE;
          end
          ST_CHECK: begin
            if (acmd41_busy) begin
              state_q <= ST_PAUSE;
            end else if (step_q == STEP_CMD7) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              if (step_q == STEP_ACMD41) ccs_q <= resp_hi_q[14];
              if (step_q == STEP_CMD3)   rca_q <= resp_hi_q;
              index_q   <= step_index(issue_step);
              arg_q     <= step_arg(issue_step, issue_rca);
              to_en_q   <= (issue_step != STEP_CMD0);
              new_cmd_q <= 1'b1;
              step_q    <= issue_step;
              state_q   <= ST_WAIT;
            end
          end
          ST_ISSUE: begin
            index_q   <= step_index(issue_step);
            arg_q     <= step_arg(issue_step, issue_rca);
            to_en_q   <= (issue_step != STEP_CMD0);
            new_cmd_q <= 1'b1;
            state_q   <= ST_WAIT;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_new_command = new_cmd_q;
  assign cmd_index       = index_q;
  assign cmd_argument    = arg_q;
  assign cmd_timeout_en  = to_en_q;
  assign busy            = busy_q;
  assign init_done       = done_q;
  assign init_error      = error_q;
  assign error_code      = code_q;
  assign error_cmd       = error_cmd_q;
  assign card_rca        = rca_q;
  assign card_ccs        = ccs_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Drives the sequencer as a simulated card/cmd_controller and checks every issued command
// and the final status against a command-list model built from the sequence rules.
module tb_sd_init_sequencer;

  localparam int MAX_RETRIES = 4;
  localparam int RETRY_WAIT  = 16;

  logic        clock = 1'b0;
  logic        reset, start, abort, cmd_complete, cmd_timeout;
  logic [31:0] cmd_response;
  logic        cmd_new_command, cmd_timeout_en, busy, init_done, init_error, card_ccs;
  logic [5:0]  cmd_index, error_cmd;
  logic [31:0] cmd_argument;
  logic [2:0]  error_code;
  logic [15:0] card_rca;

  int total = 0;
  int bad   = 0;
  int pulse_cnt = 0;

  typedef struct {
    logic [31:0] cmd8_resp;
    int          n_busy;   // busy ACMD41 answers before the ready one
    logic        ccs;
    logic [15:0] rca;
    int          to_cmd;   // command index answered by timeout, -1 for none
    bit          both;     // timeout arrives together with complete
  } scen_t;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        ten;
    bit          after_pause;
  } exp_cmd_t;

  exp_cmd_t    exp_q[$];
  logic [2:0]  exp_code;
  logic [5:0]  exp_ecmd;
  logic        exp_done;
  logic [15:0] exp_rca;
  logic        exp_ccs;

  sd_init_sequencer #(.MAX_RETRIES(MAX_RETRIES), .RETRY_WAIT(RETRY_WAIT)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .cmd_new_command (cmd_new_command),
    .cmd_index       (cmd_index),
    .cmd_argument    (cmd_argument),
    .cmd_timeout_en  (cmd_timeout_en),
    .cmd_complete    (cmd_complete),
    .cmd_timeout     (cmd_timeout),
    .cmd_response    (cmd_response),
    .busy            (busy),
    .init_done       (init_done),
    .init_error      (init_error),
    .error_code      (error_code),
    .error_cmd       (error_cmd),
    .card_rca        (card_rca),
    .card_ccs        (card_ccs)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (cmd_new_command === 1'b1) pulse_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Model: append one issued command; tells the caller whether it ends the run by timeout.
  task automatic push_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit pause,
                          input scen_t s, output bit stop);
    exp_cmd_t e;
    e.idx = idx; e.arg = arg; e.ten = (idx != 6'd0); e.after_pause = pause;
    exp_q.push_back(e);
    stop = (int'(idx) == s.to_cmd);
    if (stop) begin exp_code = 3'd1; exp_ecmd = idx; end
  endtask

  task automatic build_model(input scen_t s);
    bit stop;
    exp_q.delete();
    exp_code = 3'd0; exp_ecmd = 6'd0; exp_done = 1'b0; exp_rca = 16'h0; exp_ccs = 1'b0;
    push_cmd(6'd0, 32'h0, 1'b0, s, stop);          if (stop) return;
    push_cmd(6'd8, 32'h1AA, 1'b0, s, stop);        if (stop) return;
    if (s.cmd8_resp[11:0] != 12'h1AA) begin exp_code = 3'd2; exp_ecmd = 6'd8; return; end
    for (int k = 0; k < MAX_RETRIES; k++) begin
      push_cmd(6'd55, 32'h0, k > 0, s, stop);      if (stop) return;
      push_cmd(6'd41, 32'h40FF8000, 1'b0, s, stop); if (stop) return;
      if (k >= s.n_busy) break;
      if (k == MAX_RETRIES - 1) begin exp_code = 3'd3; exp_ecmd = 6'd41; return; end
    end
    exp_ccs = s.ccs;
    push_cmd(6'd2, 32'h0, 1'b0, s, stop);          if (stop) return;
    push_cmd(6'd3, 32'h0, 1'b0, s, stop);          if (stop) return;
    exp_rca = s.rca;
    push_cmd(6'd7, {s.rca, 16'h0}, 1'b0, s, stop); if (stop) return;
    exp_done = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; start = 1'b0; abort = 1'b0; cmd_complete = 1'b0; cmd_timeout = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
  endtask

  // Called on the first falling edge after the triggering event was sampled.
  task automatic wait_pulse(input int limit, output int k, output bit ok);
    k = 1; ok = 1'b0;
    while (k <= limit) begin
      if (cmd_new_command === 1'b1) begin ok = 1'b1; return; end
      @(negedge clock);
      k++;
    end
  endtask

  task automatic run_scenario(input scen_t s);
    exp_cmd_t e;
    int k, base, acmd_n;
    bit ok, last_to;
    build_model(s);
    acmd_n = 0;
    base = pulse_cnt;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      wait_pulse(RETRY_WAIT + 40, k, ok);
      total++;
      if (!ok) begin
        $display("FAIL pulse_wait: no new_command for cmd%0d, required one", e.idx);
        bad++; do_reset(); return;
      end
      total++;
      if (e.after_pause ? (k < RETRY_WAIT) : (k != 2)) begin
        $display("FAIL latency cmd%0d: got %0d cycles, required %s", e.idx, k,
                 e.after_pause ? ">= RETRY_WAIT" : "2");
        bad++;
      end
      total++;
      if ({cmd_index, cmd_argument, cmd_timeout_en} !== {e.idx, e.arg, e.ten}) begin
        $display("FAIL command: got idx=%0d arg=%h ten=%b, required idx=%0d arg=%h ten=%b",
                 cmd_index, cmd_argument, cmd_timeout_en, e.idx, e.arg, e.ten);
        bad++;
      end
      @(negedge clock);
      total++;
      if (cmd_new_command !== 1'b0) begin
        $display("FAIL pulse_width cmd%0d: new_command=%b, required 0", e.idx, cmd_new_command);
        bad++;
      end
      repeat ($urandom_range(0, 3)) @(negedge clock);
      total++;
      if (cmd_index !== e.idx || busy !== 1'b1) begin
        $display("FAIL hold: got idx=%0d busy=%b, required idx=%0d busy=1", cmd_index, busy, e.idx);
        bad++;
      end
      last_to = (i == exp_q.size() - 1) && (exp_code == 3'd1);
      if (last_to) begin
        cmd_timeout  = 1'b1;
        cmd_complete = s.both;
      end else begin
        cmd_complete = 1'b1;
        case (e.idx)
          6'd8:    cmd_response = s.cmd8_resp;
          6'd3:    cmd_response = {s.rca, 16'($urandom)};
          6'd41: begin
            if (acmd_n < s.n_busy) cmd_response = {1'b0, 31'($urandom)};
            else                   cmd_response = {1'b1, s.ccs, 30'($urandom)};
            acmd_n++;
          end
          default: cmd_response = $urandom;
        endcase
      end
      @(negedge clock);
      cmd_complete = 1'b0; cmd_timeout = 1'b0; cmd_response = $urandom;
    end
    repeat (RETRY_WAIT + 10) @(negedge clock);
    total++;
    if ({busy, init_done, init_error, error_code, error_cmd, card_rca, card_ccs} !==
        {1'b0, exp_done, !exp_done, exp_code, exp_ecmd, exp_rca, exp_ccs}) begin
      $display("FAIL final: got done=%b err=%b code=%0d ecmd=%0d rca=%h ccs=%b busy=%b, required done=%b err=%b code=%0d ecmd=%0d rca=%h ccs=%b busy=0",
               init_done, init_error, error_code, error_cmd, card_rca, card_ccs, busy,
               exp_done, !exp_done, exp_code, exp_ecmd, exp_rca, exp_ccs);
      bad++;
    end
    total++;
    if (pulse_cnt - base != exp_q.size()) begin
      $display("FAIL pulse_count: got %0d, required %0d", pulse_cnt - base, exp_q.size());
      bad++;
    end
  endtask

  task automatic test_reset();
    int base;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    cmd_complete = 1'b0; cmd_timeout = 1'b0; cmd_response = 32'h0;
    repeat (3) @(negedge clock);
    total++;
    if ({cmd_new_command, cmd_index, cmd_argument, cmd_timeout_en, busy, init_done, init_error,
         error_code, error_cmd, card_rca, card_ccs} !== '0) begin
      $display("FAIL reset_outputs: some output nonzero (busy=%b done=%b err=%b idx=%0d)",
               busy, init_done, init_error, cmd_index);
      bad++;
    end
    reset = 1'b1;
    base = pulse_cnt;
    @(negedge clock); cmd_complete = 1'b1; cmd_timeout = 1'b1; cmd_response = 32'hFFFF_FFFF;
    @(negedge clock); cmd_complete = 1'b0; cmd_timeout = 1'b0;
    repeat (5) @(negedge clock);
    total++;
    if (busy !== 1'b0 || init_error !== 1'b0 || init_done !== 1'b0 || pulse_cnt != base) begin
      $display("FAIL idle_stray: got busy=%b err=%b done=%b pulses=%0d, required all 0",
               busy, init_error, init_done, pulse_cnt - base);
      bad++;
    end
  endtask

  task automatic test_basic();
    scen_t s;
    int base;
    s = '{32'h0000_01AA, 0, 1'b1, 16'h1234, -1, 1'b0};
    run_scenario(s);
    total++;
    if (init_done !== 1'b1 || card_rca !== 16'h1234 || card_ccs !== 1'b1) begin
      $display("FAIL basic_status: got done=%b rca=%h ccs=%b, required 1 1234 1",
               init_done, card_rca, card_ccs);
      bad++;
    end
    base = pulse_cnt;
    @(negedge clock); cmd_timeout = 1'b1; cmd_complete = 1'b1;
    @(negedge clock); cmd_timeout = 1'b0; cmd_complete = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (init_done !== 1'b1 || init_error !== 1'b0 || pulse_cnt != base) begin
      $display("FAIL done_stray: got done=%b err=%b, required done=1 err=0", init_done, init_error);
      bad++;
    end
  endtask

  task automatic test_retry();
    scen_t s;
    s = '{32'h0000_01AA, 2, 1'b0, 16'($urandom), -1, 1'b0};
    run_scenario(s);
  endtask

  task automatic test_retry_limit();
    scen_t s;
    s = '{32'h0000_01AA, 100, 1'b1, 16'($urandom), -1, 1'b0};
    run_scenario(s);
  endtask

  task automatic test_cmd8_echo();
    scen_t s;
    s = '{32'h0000_01A5, 0, 1'b1, 16'($urandom), -1, 1'b0};
    run_scenario(s);
  endtask

  task automatic test_timeout_priority();
    scen_t s;
    s = '{32'h0000_01AA, 1, 1'b1, 16'($urandom), 2, 1'b1};
    run_scenario(s);
  endtask

  task automatic test_random();
    scen_t s;
    int to_pick[8];
    to_pick = '{-1, -1, 8, 55, 41, 2, 3, 7};
    for (int n = 0; n < 8; n++) begin
      s.cmd8_resp = ($urandom_range(0, 5) == 0) ? $urandom : {20'($urandom), 12'h1AA};
      s.n_busy    = $urandom_range(0, 5);
      s.ccs       = 1'($urandom);
      s.rca       = 16'($urandom);
      s.to_cmd    = to_pick[$urandom_range(0, 7)];
      s.both      = 1'($urandom);
      run_scenario(s);
    end
  endtask

  task automatic test_abort_reset();
    scen_t s;
    int k, base;
    bit ok;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_pulse(10, k, ok);
    total++;
    if (!ok || cmd_index !== 6'd0) begin
      $display("FAIL abort_cmd0: got pulse=%b idx=%0d, required pulse=1 idx=0", ok, cmd_index);
      bad++;
    end
    @(negedge clock);
    base = pulse_cnt;
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    repeat (5) @(negedge clock);
    total++;
    if (pulse_cnt != base || busy !== 1'b1 || cmd_index !== 6'd0) begin
      $display("FAIL start_ignored: got pulses=%0d busy=%b idx=%0d, required 0 1 0",
               pulse_cnt - base, busy, cmd_index);
      bad++;
    end
    cmd_complete = 1'b1;
    @(negedge clock); cmd_complete = 1'b0;
    wait_pulse(10, k, ok);
    @(negedge clock);
    abort = 1'b1; cmd_complete = 1'b1; cmd_response = 32'h0000_01AA;
    @(negedge clock);
    abort = 1'b0; cmd_complete = 1'b0;
    base = pulse_cnt;
    repeat (20) @(negedge clock);
    total++;
    if (init_error !== 1'b1 || error_code !== 3'd4 || busy !== 1'b0 || init_done !== 1'b0 ||
        pulse_cnt != base) begin
      $display("FAIL abort: got err=%b code=%0d busy=%b done=%b pulses=%0d, required 1 4 0 0 0",
               init_error, error_code, busy, init_done, pulse_cnt - base);
      bad++;
    end
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    wait_pulse(10, k, ok);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++;
    if ({cmd_new_command, cmd_index, cmd_argument, cmd_timeout_en, busy, init_done, init_error,
         error_code, error_cmd, card_rca, card_ccs} !== '0) begin
      $display("FAIL midwait_reset: got busy=%b err=%b code=%0d pulse=%b, required all 0",
               busy, init_error, error_code, cmd_new_command);
      bad++;
    end
    reset = 1'b1;
    base = pulse_cnt;
    repeat (10) @(negedge clock);
    total++;
    if (pulse_cnt != base || busy !== 1'b0) begin
      $display("FAIL post_reset_idle: got pulses=%0d busy=%b, required 0 0", pulse_cnt - base, busy);
      bad++;
    end
    s = '{32'h0000_01AA, 1, 1'b1, 16'hBEEF, -1, 1'b0};
    run_scenario(s);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_retry_limit();
    test_cmd8_echo();
    test_timeout_priority();
    test_random();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
